// File: rtl/reg_alu_sequencer_if.sv
// Command channel into the A/B/C register + ALU sequencer.
// The master issues commands; the sequencer (slave) accepts them with cmd_ready.
interface reg_alu_sequencer_if #(
    parameter int COUNT_W = 4
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_type;
    logic               cmd_dec;
    logic [1:0]         cmd_op;
    logic [1:0]         cmd_src;
    logic [1:0]         cmd_dst;
    logic [COUNT_W-1:0] cmd_count;

    modport master (
        output cmd_valid, cmd_type, cmd_dec, cmd_op,
        output cmd_src, cmd_dst, cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_dec, cmd_op,
        input  cmd_src, cmd_dst, cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/reg_alu_sequencer.sv
// Command-driven sequencer for the A/B/C register + ALU datapath:
// turns each accepted command into repeated, settle-spaced load strobes.
module reg_alu_sequencer #(
    parameter int COUNT_W = 4,
    parameter int SETTLE  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_alu_sequencer_if.slave   cmd,
    input  logic                 abort,
    output logic                 load_a,
    output logic                 load_b,
    output logic                 load_c,
    output logic                 in_sel,
    output logic                 dec_a,
    output logic                 dec_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           bus_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        WAIT,
        DONE
    } state_t;

    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WW-1:0] WLAST = WW'(SETTLE - 1);
    localparam logic [COUNT_W:0] FULL = {1'b1, {COUNT_W{1'b0}}};
    localparam logic [COUNT_W:0] ONE = (COUNT_W+1)'(1);

    localparam logic [1:0] T_STEP_A = 2'd0;
    localparam logic [1:0] T_STEP_B = 2'd1;
    localparam logic [1:0] T_EXEC   = 2'd2;
    localparam logic [1:0] T_MOVE   = 2'd3;

    state_t           state_q, state_d;
    logic [COUNT_W:0] rep_q, rep_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [1:0]       typ_q, typ_d;
    logic [1:0]       dst_q, dst_d;
    logic             load_a_q, load_a_d;
    logic             load_b_q, load_b_d;
    logic             load_c_q, load_c_d;
    logic             in_sel_q, in_sel_d;
    logic             dec_a_q, dec_a_d;
    logic             dec_b_q, dec_b_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic [1:0]       bus_sel_q, bus_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             idle_q, idle_d;

    always_comb begin
        state_d   = state_q;
        rep_d     = rep_q;
        wcnt_d    = wcnt_q;
        typ_d     = typ_q;
        dst_d     = dst_q;
        in_sel_d  = in_sel_q;
        dec_a_d   = dec_a_q;
        dec_b_d   = dec_b_q;
        alu_op_d  = alu_op_q;
        bus_sel_d = bus_sel_q;

        unique case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    typ_d   = cmd.cmd_type;
                    dst_d   = cmd.cmd_dst;
                    rep_d   = (cmd.cmd_count == '0) ? FULL
                                                    : {1'b0, cmd.cmd_count};
                    state_d = SETUP;
                    // Only the selects a command uses are updated.
                    unique case (cmd.cmd_type)
                        T_STEP_A: begin
                            in_sel_d = 1'b0;
                            dec_a_d  = cmd.cmd_dec;
                        end
                        T_STEP_B: begin
                            in_sel_d = 1'b0;
                            dec_b_d  = cmd.cmd_dec;
                        end
                        T_EXEC: begin
                            in_sel_d = 1'b0;
                            alu_op_d = cmd.cmd_op;
                        end
                        T_MOVE: begin
                            in_sel_d  = 1'b1;
                            bus_sel_d = cmd.cmd_src;
                        end
                        default: ;
                    endcase
                end
            end
            SETUP: state_d = abort ? DONE : LOAD;
            LOAD: begin
                rep_d = rep_q - ONE;
                if (abort || rep_q == ONE) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    wcnt_d  = WLAST;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = DONE;
                end else if (wcnt_q == '0) begin
                    state_d = LOAD;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes and status are registered from the next state.
        load_a_d  = 1'b0;
        load_b_d  = 1'b0;
        load_c_d  = 1'b0;
        if (state_d == LOAD) begin
            unique case (typ_d)
                T_STEP_A: load_a_d = 1'b1;
                T_STEP_B: load_b_d = 1'b1;
                T_EXEC:   load_c_d = 1'b1;
                T_MOVE: begin
                    load_a_d = (dst_d == 2'd0) || (dst_d == 2'd3);
                    load_b_d = (dst_d == 2'd1) || (dst_d == 2'd3);
                    load_c_d = (dst_d == 2'd2) || (dst_d == 2'd3);
                end
                default: ;
            endcase
        end
        done_d    = (state_d == DONE);
        aborted_d = (state_d == DONE) && abort;
        busy_d    = (state_d != IDLE);
        idle_d    = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rep_q     <= '0;
            wcnt_q    <= '0;
            typ_q     <= '0;
            dst_q     <= '0;
            load_a_q  <= 1'b0;
            load_b_q  <= 1'b0;
            load_c_q  <= 1'b0;
            in_sel_q  <= 1'b0;
            dec_a_q   <= 1'b0;
            dec_b_q   <= 1'b0;
            alu_op_q  <= '0;
            bus_sel_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            rep_q     <= rep_d;
            wcnt_q    <= wcnt_d;
            typ_q     <= typ_d;
            dst_q     <= dst_d;
            load_a_q  <= load_a_d;
            load_b_q  <= load_b_d;
            load_c_q  <= load_c_d;
            in_sel_q  <= in_sel_d;
            dec_a_q   <= dec_a_d;
            dec_b_q   <= dec_b_d;
            alu_op_q  <= alu_op_d;
            bus_sel_q <= bus_sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            idle_q    <= idle_d;
        end
    end

    // Ready is masked by rst so no command is offered while held in reset.
    assign cmd.cmd_ready = idle_q & ~rst;
    assign load_a  = load_a_q;
    assign load_b  = load_b_q;
    assign load_c  = load_c_q;
    assign in_sel  = in_sel_q;
    assign dec_a   = dec_a_q;
    assign dec_b   = dec_b_q;
    assign alu_op  = alu_op_q;
    assign bus_sel = bus_sel_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Bench for reg_alu_sequencer: directed cases plus random commands
// compared cycle by cycle against a timeline model of each command.
module tb_reg_alu_sequencer;

    localparam int CW = 4;
    localparam int ST = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort = 1'b0;
    logic       load_a, load_b, load_c, in_sel, dec_a, dec_b;
    logic [1:0] alu_op, bus_sel;
    logic       busy, done, aborted;

    int checks = 0;
    int errors = 0;

    logic       m_in_sel = 1'b0;
    logic       m_dec_a = 1'b0;
    logic       m_dec_b = 1'b0;
    logic [1:0] m_alu = 2'd0;
    logic [1:0] m_bus = 2'd0;

    reg_alu_sequencer_if #(.COUNT_W(CW)) cif ();

    always #5 clk = ~clk;

    reg_alu_sequencer #(.COUNT_W(CW), .SETTLE(ST)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cif.slave),
        .abort   (abort),
        .load_a  (load_a),
        .load_b  (load_b),
        .load_c  (load_c),
        .in_sel  (in_sel),
        .dec_a   (dec_a),
        .dec_b   (dec_b),
        .alu_op  (alu_op),
        .bus_sel (bus_sel),
        .busy    (busy),
        .done    (done),
        .aborted (aborted)
    );

    // {ready, busy, la, lb, lc, done, aborted, in_sel, dec_a, dec_b, alu, bus}
    function automatic logic [13:0] obs();
        return {cif.cmd_ready, busy, load_a, load_b, load_c, done, aborted,
                in_sel, dec_a, dec_b, alu_op, bus_sel};
    endfunction

    function automatic logic [13:0] expv(logic rdy, logic bsy,
                                         logic [2:0] ld, logic dn,
                                         logic ab);
        return {rdy, bsy, ld, dn, ab, m_in_sel, m_dec_a, m_dec_b,
                m_alu, m_bus};
    endfunction

    task automatic chk(input string tag, input logic [13:0] got,
                       input logic [13:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, got, exp);
        end
    endtask

    // Runs one command; abort_k >= 0 pulses abort during load number abort_k.
    task automatic run_cmd(input logic [1:0] ty, input logic d,
                           input logic [1:0] op, input logic [1:0] src,
                           input logic [1:0] dst, input logic [CW-1:0] cnt,
                           input int abort_k, input string tag);
        int n, nl, done_t, waited;
        logic [2:0] lm;
        logic ab, is_load;
        cif.cmd_type  = ty;
        cif.cmd_dec   = d;
        cif.cmd_op    = op;
        cif.cmd_src   = src;
        cif.cmd_dst   = dst;
        cif.cmd_count = cnt;
        cif.cmd_valid = 1'b1;
        waited = 0;
        while (cif.cmd_ready !== 1'b1 && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        assert (cif.cmd_ready === 1'b1) else begin
            errors++;
            $error("FAIL %s_accept observed %b expected 1",
                   tag, cif.cmd_ready);
            cif.cmd_valid = 1'b0;
            return;
        end
        case (ty)
            2'd0: begin m_in_sel = 1'b0; m_dec_a = d; lm = 3'b100; end
            2'd1: begin m_in_sel = 1'b0; m_dec_b = d; lm = 3'b010; end
            2'd2: begin m_in_sel = 1'b0; m_alu = op; lm = 3'b001; end
            default: begin
                m_in_sel = 1'b1;
                m_bus = src;
                lm = (dst == 2'd3) ? 3'b111 : (3'b100 >> dst);
            end
        endcase
        n = (cnt == 0) ? (1 << CW) : int'(cnt);
        ab = (abort_k >= 0) && (abort_k < n);
        nl = ab ? abort_k + 1 : n;
        done_t = 2 + (nl - 1) * (ST + 1) + 1;
        for (int t = 1; t <= done_t + 1; t++) begin
            @(posedge clk);
            #1;
            abort = ab && (t == 2 + abort_k * (ST + 1));
            is_load = (t >= 2) && ((t - 2) % (ST + 1) == 0)
                      && ((t - 2) / (ST + 1) < nl);
            chk($sformatf("%s_t%0d", tag, t), obs(),
                expv(t == done_t + 1, t <= done_t,
                     is_load ? lm : 3'b000, t == done_t,
                     (t == done_t) && ab));
        end
        abort = 1'b0;
        cif.cmd_valid = 1'b0;
    endtask

    initial begin
        logic [1:0] rty, rop, rsrc, rdst;
        logic [CW-1:0] rcnt;
        logic rd;
        int rn, rk;

        cif.cmd_valid = 1'b1;
        cif.cmd_type  = 2'd0;
        cif.cmd_dec   = 1'b0;
        cif.cmd_op    = 2'd0;
        cif.cmd_src   = 2'd0;
        cif.cmd_dst   = 2'd0;
        cif.cmd_count = '0;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset", obs(), 14'd0);
        end
        cif.cmd_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("reset_release", obs(), expv(1'b1, 1'b0, 3'b000, 1'b0, 1'b0));

        run_cmd(2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 4'd3, -1, "step_a_x3");
        run_cmd(2'd2, 1'b0, 2'd2, 2'd0, 2'd0, 4'd1, -1, "exec_op2");
        run_cmd(2'd3, 1'b0, 2'd0, 2'd3, 2'd3, 4'd1, -1, "move_all");
        run_cmd(2'd1, 1'b1, 2'd0, 2'd0, 2'd0, 4'd0, -1, "step_b_x16");
        run_cmd(2'd0, 1'b1, 2'd0, 2'd0, 2'd0, 4'd5, 1, "step_a_abort");
        run_cmd(2'd2, 1'b0, 2'd1, 2'd0, 2'd0, 4'd2, -1, "after_abort");
        run_cmd(2'd3, 1'b0, 2'd0, 2'd1, 2'd2, 4'd2, 1, "move_abort_last");

        // Reset during a WAIT cycle of a repeating command.
        cif.cmd_type  = 2'd0;
        cif.cmd_dec   = 1'b1;
        cif.cmd_count = 4'd5;
        cif.cmd_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        cif.cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_wait", obs(), 14'd0);
        rst = 1'b0;
        m_in_sel = 1'b0;
        m_dec_a = 1'b0;
        m_dec_b = 1'b0;
        m_alu = 2'd0;
        m_bus = 2'd0;
        #1;
        chk("rst_wait_release", obs(),
            expv(1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        chk("rst_wait_no_done", obs(),
            expv(1'b1, 1'b0, 3'b000, 1'b0, 1'b0));

        for (int i = 0; i < 24; i++) begin
            rty  = 2'($urandom_range(0, 3));
            rd   = 1'($urandom_range(0, 1));
            rop  = 2'($urandom_range(0, 3));
            rsrc = 2'($urandom_range(0, 3));
            rdst = 2'($urandom_range(0, 3));
            rcnt = CW'($urandom_range(0, 15));
            rn = (rcnt == 0) ? (1 << CW) : int'(rcnt);
            rk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rn - 1))
                                             : -1;
            run_cmd(rty, rd, rop, rsrc, rdst, rcnt, rk,
                    $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_alu_sequencer.md
Name: reg_alu_sequencer

Overview:
- Command-driven controller that sits directly upstream of the A/B/C register + ALU datapath.
- Replaces the manual switch and debounced-button load path with a valid/ready command interface.
- Drives load strobes, the input-select mux, the inc/dec controls, the ALU opcode and the bus select.
- Each command can repeat its load up to 2^COUNT_W times, with settle gaps between loads.

Parameters:
- COUNT_W, 4: width of the repeat-count field; cmd_count==0 means 2^COUNT_W repetitions.
- SETTLE, 2: idle cycles between consecutive loads of one command (legal range ≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE while rst low.
- cmd_type  in  2  0 STEP_A, 1 STEP_B, 2 EXEC, 3 MOVE.
- cmd_dec  in  1  STEP_A/STEP_B: 0 increment, 1 decrement.
- cmd_op  in  2  EXEC: ALU opcode.
- cmd_src  in  2  MOVE: bus source; 0 A, 1 B, 2 C, 3 constant zero.
- cmd_dst  in  2  MOVE: destination; 0 A, 1 B, 2 C, 3 all three.
- cmd_count  in  COUNT_W  repetition count.
- abort  in  1  terminate the current command early.
- load_a, load_b, load_c  out  1 each  single-cycle register load strobes.
- in_sel  out  1  0 selects the step/ALU path, 1 selects the bus.
- dec_a, dec_b  out  1 each  inc/dec control for A and B.
- alu_op  out  2  ALU opcode.
- bus_sel  out  2  bus mux select.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  qualifies done; high if the command was aborted.

Behaviour:
- Reset values: state IDLE; every output 0, including cmd_ready during reset and rep counter 0.
- All outputs are registered or Moore-decoded from state. No combinational input-to-output path.
- States: IDLE, SETUP, LOAD, WAIT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch all cmd_* fields and set rep = (cmd_count==0) ? 2^COUNT_W : cmd_count (COUNT_W+1 bits).
  - Drive the selects from the latched fields, then go to SETUP.
- SETUP:
  - Exactly 1 cycle; selects stable, all loads 0.
  - Go to LOAD.
- LOAD:
  - Exactly 1 cycle; assert the load strobe(s) for the command. rep decrements at the end of the cycle.
  - If rep becomes 0, go to DONE; otherwise go to WAIT.
- WAIT:
  - SETTLE cycles, counted by an internal counter; loads 0, selects held.
  - Then go to LOAD. There is no SETUP on repeats.
- DONE:
  - 1 cycle; done=1; aborted reflects the abort flag.
  - Go to IDLE and clear the abort flag.
- Select and strobe mapping per command:
  - STEP_A: in_sel=0, dec_a=cmd_dec, load_a.
  - STEP_B: in_sel=0, dec_b=cmd_dec, load_b.
  - EXEC: in_sel=0, alu_op=cmd_op, load_c.
  - MOVE: in_sel=1, bus_sel=cmd_src; loads per cmd_dst, where dst 3 asserts load_a, load_b and load_c together.
- Fields that a command does not use keep their previous values. All selects hold their last values through DONE and IDLE until the next accept.
- Latency: with the accept edge at cycle T, load k (k=0..N-1) is high in cycle T+2+k·(SETTLE+1). done is high in the cycle after the last load.
- Abort:
  - Sampled in SETUP, LOAD or WAIT; next state is DONE with aborted=1.
  - A load already asserted in the current LOAD cycle still completes. No further loads occur.
  - abort is ignored in IDLE and DONE.
- cmd_valid held high through DONE: the next command is accepted only in IDLE. This gives a minimum 1 idle cycle between commands.
- rst mid-command: on the next cycle, state is IDLE, all strobes are 0 and done does not pulse.
- Count 0 gives 16 loads (with COUNT_W=4). Count 1 gives a single load with no WAIT.

Test Plan:
- Reset: hold rst for 3 cycles with cmd_valid=1. Required: cmd_ready=0, all outputs 0, no accept. On release, cmd_ready=1 in the first cycle.
- STEP_A, dec=0, count=3, SETTLE=2, accepted at T. Required: load_a high at T+2, T+5 and T+8 only; in_sel=0 and dec_a=0 throughout; done at T+9; cmd_ready back at T+10.
- EXEC, op=2, count=1. Required: alu_op=2 from T+1; single load_c at T+2; done at T+3; load_a=load_b=0 throughout.
- MOVE, src=3, dst=3, count=1. Required: in_sel=1, bus_sel=3; load_a, load_b and load_c all high in the same single cycle T+2.
- STEP_B, count=0. Required: exactly 16 load_b pulses spaced 3 cycles apart; done one cycle after the 16th pulse.
- STEP_A, count=5, abort pulsed during the 2nd LOAD cycle. Required: exactly 2 load_a pulses; done=1 and aborted=1 the next cycle; the next command completes with aborted=0. Variant: rst in a WAIT cycle gives IDLE with no done pulse.
